// File: rtl/text_buffer_ctrl.sv
// rtl/text_buffer_ctrl.sv - shadow/active text string buffer with arbitrated writers and frame-synchronous commit
// Optional feature macro: TEXT_BLINK_EN (frame-counted colour blink)
module text_buffer_ctrl #(
  parameter int          L            = 10,
  parameter int          IW           = 6,
  parameter logic [7:0]  BLANK        = 8'd32,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_stb,
  input  logic            req0_valid,
  input  logic [IW-1:0]   req0_idx,
  input  logic [7:0]      req0_code,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [IW-1:0]   req1_idx,
  input  logic [7:0]      req1_code,
  output logic            req1_ready,
  input  logic            cfg_valid,
  input  logic [9:0]      cfg_pos_x,
  input  logic [9:0]      cfg_pos_y,
  input  logic [2:0]      cfg_collor,
  input  logic            clear,
  input  logic            blink_on,
  output logic [8*L-1:0]  text_data,
  output logic [9:0]      pos_x,
  output logic [9:0]      pos_y,
  output logic [2:0]      collor,
  output logic            busy,
  output logic            pending,
  output logic            err_oob
);

  localparam logic [0:0]    S_IDLE  = 1'b0;
  localparam logic [0:0]    S_CLEAR = 1'b1;
  localparam logic [IW:0]   L_W     = (IW+1)'(L);
  localparam logic [IW-1:0] LAST    = IW'(L - 1);

  logic [0:0]    state;
  logic [IW-1:0] clr_idx;
  logic          rr_ptr;
  logic [7:0]    shadow [L];
  logic [7:0]    active [L];
  logic [9:0]    sh_x, sh_y;
  logic [2:0]    sh_col, act_col;

  logic          idle, clearing, clr_last, commit;
  logic          wr_en, wr_ok;
  logic [IW-1:0] wr_idx;
  logic [7:0]    wr_code;

  assign idle     = (state == S_IDLE);
  assign clearing = (state == S_CLEAR);
  assign clr_last = clearing && (clr_idx == LAST);

  // rr_ptr=1 means requester 1 has priority when both are valid.
  assign req0_ready = rst_n & idle & req0_valid & (~req1_valid | ~rr_ptr);
  assign req1_ready = rst_n & idle & req1_valid & (~req0_valid | rr_ptr);

  assign wr_en   = req0_ready | req1_ready;
  assign wr_idx  = req1_ready ? req1_idx  : req0_idx;
  assign wr_code = req1_ready ? req1_code : req0_code;
  assign wr_ok   = wr_en && ({1'b0, wr_idx} < L_W);
  assign commit  = frame_stb & idle & pending;

  assign busy = clearing;

  always_comb begin
    text_data = '0;
    for (int k = 0; k < L; k++) text_data[8*(L-1-k) +: 8] = active[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      clr_idx <= '0;
      rr_ptr  <= 1'b0;
      pending <= 1'b0;
      err_oob <= 1'b0;
      sh_x    <= '0;
      sh_y    <= '0;
      sh_col  <= 3'b111;
      pos_x   <= '0;
      pos_y   <= '0;
      act_col <= 3'b111;
      for (int k = 0; k < L; k++) begin
        shadow[k] <= BLANK;
        active[k] <= BLANK;
      end
    end else begin
      // Commit copies the pre-edge shadow, so a same-cycle write waits for the next strobe.
      if (commit) begin
        for (int k = 0; k < L; k++) active[k] <= shadow[k];
        pos_x   <= sh_x;
        pos_y   <= sh_y;
        act_col <= sh_col;
      end
      for (int k = 0; k < L; k++) begin
        if (wr_ok && wr_idx == IW'(k))
          shadow[k] <= wr_code;
        else if (clearing && clr_idx == IW'(k))
          shadow[k] <= BLANK;
      end
      if (wr_en) rr_ptr <= req0_ready;
      err_oob <= wr_en & ~wr_ok;
      if (cfg_valid) begin
        sh_x   <= cfg_pos_x;
        sh_y   <= cfg_pos_y;
        sh_col <= cfg_collor;
      end
      case (state)
        S_IDLE: if (clear) begin
          state   <= S_CLEAR;
          clr_idx <= '0;
        end
        default: if (clr_last) state <= S_IDLE;
                 else clr_idx <= clr_idx + 1'b1;
      endcase
      if (commit)
        pending <= wr_ok | cfg_valid;
      else if (wr_ok | cfg_valid | clr_last)
        pending <= 1'b1;
    end
  end

`ifdef TEXT_BLINK_EN
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [CW-1:0] frame_cnt;
  logic          phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (frame_stb) begin
      if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign collor = (blink_on & phase) ? 3'b000 : act_col;
`else
  logic unused_blink;
  assign unused_blink = blink_on ^ (BLINK_FRAMES == 0);
  assign collor       = act_col;
`endif

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// tb/tb_text_buffer_ctrl.sv - scoreboard bench for text_buffer_ctrl with directed and random traffic
module tb_text_buffer_ctrl;
  localparam int L  = 10;
  localparam int IW = 6;
  localparam int BF = 2;
  localparam int BLANK = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_stb = 0, req0_valid = 0, req1_valid = 0, cfg_valid = 0, clear = 0, blink_on = 0;
  logic [IW-1:0] req0_idx = '0, req1_idx = '0;
  logic [7:0] req0_code = '0, req1_code = '0;
  logic [9:0] cfg_pos_x = '0, cfg_pos_y = '0;
  logic [2:0] cfg_collor = '0;
  logic req0_ready, req1_ready, busy, pending, err_oob;
  logic [8*L-1:0] text_data;
  logic [9:0] pos_x, pos_y;
  logic [2:0] collor;

  always #5 clk = ~clk;

  text_buffer_ctrl #(.L(L), .IW(IW), .BLANK(8'd32), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .frame_stb(frame_stb),
    .req0_valid(req0_valid), .req0_idx(req0_idx), .req0_code(req0_code), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_idx(req1_idx), .req1_code(req1_code), .req1_ready(req1_ready),
    .cfg_valid(cfg_valid), .cfg_pos_x(cfg_pos_x), .cfg_pos_y(cfg_pos_y), .cfg_collor(cfg_collor),
    .clear(clear), .blink_on(blink_on), .text_data(text_data), .pos_x(pos_x), .pos_y(pos_y),
    .collor(collor), .busy(busy), .pending(pending), .err_oob(err_oob));

  typedef struct {
    logic r0, r1, busy, pend, err;
    logic [8*L-1:0] txt;
    logic [9:0] px, py;
    logic [2:0] col;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0;

  // Reference model: plain arrays and counters describing what the renderer should see.
  int shadow[L], active[L];
  int sx, sy, scol, ax, ay, acol;
  bit pend, err_f;
  int clear_left, last, stb_cnt;

  function automatic void model_reset();
    for (int k = 0; k < L; k++) begin shadow[k] = BLANK; active[k] = BLANK; end
    sx = 0; sy = 0; scol = 7; ax = 0; ay = 0; acol = 7;
    pend = 0; err_f = 0; clear_left = 0; last = 1; stb_cnt = 0;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.busy = (clear_left > 0);
    e.pend = pend;
    e.err  = err_f;
    for (int k = 0; k < L; k++) e.txt[8*(L-1-k) +: 8] = 8'(active[k]);
    e.px = 10'(ax);
    e.py = 10'(ay);
`ifdef TEXT_BLINK_EN
    e.col = (blink_on && ((stb_cnt / BF) % 2 == 1)) ? 3'b000 : 3'(acol);
`else
    e.col = 3'(acol);
`endif
    e.r0 = 0; e.r1 = 0;
    return e;
  endfunction

  task automatic predict();
    exp_t e;
    int g, idx, code;
    bit is_busy, commit, wr_in, new_err, clr_exit;
    if (!rst_n) begin
      model_reset();
      exp_q.push_back(snapshot());
      return;
    end
    is_busy = (clear_left > 0);
    g = -1;
    if (!is_busy) begin
      if (req0_valid && req1_valid) g = (last == 0) ? 1 : 0;
      else if (req0_valid) g = 0;
      else if (req1_valid) g = 1;
    end
    e = snapshot();
    e.r0 = (g == 0);
    e.r1 = (g == 1);
    exp_q.push_back(e);

    commit = frame_stb && !is_busy && pend;
    if (commit) begin
      active = shadow;
      ax = sx; ay = sy; acol = scol;
    end
    wr_in = 0; new_err = 0; clr_exit = 0;
    if (g >= 0) begin
      idx  = (g == 1) ? int'(req1_idx) : int'(req0_idx);
      code = (g == 1) ? int'(req1_code) : int'(req0_code);
      last = g;
      if (idx < L) begin shadow[idx] = code; wr_in = 1; end
      else new_err = 1;
    end
    if (is_busy) begin
      shadow[L - clear_left] = BLANK;
      clear_left--;
      clr_exit = (clear_left == 0);
    end else if (clear) begin
      clear_left = L;
    end
    if (cfg_valid) begin sx = cfg_pos_x; sy = cfg_pos_y; scol = cfg_collor; end
    pend  = commit ? (wr_in || cfg_valid) : (pend || wr_in || cfg_valid || clr_exit);
    err_f = new_err;
    if (frame_stb) stb_cnt++;
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Monitor: every negedge the DUT presents a full output set; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("req0_ready", 96'(req0_ready), 96'(e.r0));
        chk("req1_ready", 96'(req1_ready), 96'(e.r1));
        chk("busy",       96'(busy),       96'(e.busy));
        chk("pending",    96'(pending),    96'(e.pend));
        chk("err_oob",    96'(err_oob),    96'(e.err));
        chk("text_data",  96'(text_data),  96'(e.txt));
        chk("pos_x",      96'(pos_x),      96'(e.px));
        chk("pos_y",      96'(pos_y),      96'(e.py));
        chk("collor",     96'(collor),     96'(e.col));
      end
    end
  end

  task automatic tick();
    predict();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    frame_stb = 0; req0_valid = 0; req1_valid = 0; cfg_valid = 0; clear = 0;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    // Reset with both requesters asserting valid.
    rst_n = 0; req0_valid = 1; req1_valid = 1; req0_idx = 6'd3; req1_idx = 6'd4;
    repeat (3) tick();
    rst_n = 1; idle_inputs();
    tick();
    // Single write then commit.
    req0_valid = 1; req0_idx = 6'd0; req0_code = 8'd65;
    tick();
    idle_inputs();
    repeat (2) tick();
    frame_stb = 1; tick();
    frame_stb = 0; repeat (2) tick();
    // Both valid for four cycles: grants alternate.
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1; req1_valid = 1;
      req0_idx = 6'(1 + i); req0_code = 8'(66 + i);
      req1_idx = 6'(5 + i); req1_code = 8'(80 + i);
      tick();
    end
    idle_inputs();
    frame_stb = 1; tick();
    // Clear with req0 held valid, strobe mid-clear.
    frame_stb = 0; clear = 1; req0_valid = 1; req0_idx = 6'd2; req0_code = 8'd90;
    tick();
    clear = 0;
    for (int i = 0; i < 12; i++) begin
      frame_stb = (i == 4);
      tick();
    end
    idle_inputs();
    frame_stb = 1; tick();
    frame_stb = 0; tick();
    // Out-of-range write.
    req0_valid = 1; req0_idx = 6'd12; req0_code = 8'd70;
    tick();
    idle_inputs(); repeat (2) tick();
    // Config with same-cycle write and strobe.
    cfg_valid = 1; cfg_pos_x = 10'd300; cfg_pos_y = 10'd200; cfg_collor = 3'b010;
    tick();
    cfg_valid = 0; frame_stb = 1; req1_valid = 1; req1_idx = 6'd9; req1_code = 8'd77;
    tick();
    idle_inputs(); tick();
    frame_stb = 1; tick();
    idle_inputs(); blink_on = 1;
    for (int i = 0; i < 8; i++) begin frame_stb = i[0]; tick(); end
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      frame_stb  = ($urandom_range(0, 7) == 0);
      clear      = ($urandom_range(0, 39) == 0);
      cfg_valid  = ($urandom_range(0, 9) == 0);
      blink_on   = $urandom_range(0, 1) == 1;
      req0_valid = $urandom_range(0, 1) == 1;
      req1_valid = $urandom_range(0, 1) == 1;
      req0_idx   = 6'($urandom_range(0, 13));
      req1_idx   = 6'($urandom_range(0, 13));
      req0_code  = 8'($urandom_range(32, 90));
      req1_code  = 8'($urandom_range(32, 90));
      cfg_pos_x  = 10'($urandom);
      cfg_pos_y  = 10'($urandom);
      cfg_collor = 3'($urandom);
      tick();
    end
    rst_n = 1; idle_inputs();
    tick();
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
